// File: rtl/hazard_scoreboard_pkg.sv
// Purpose: shared sizing constants and FSM state encoding for the ID-stage
//          hazard scoreboard of the in-order ARM pipeline.
// Contents: NUM_REGS, REG_W, CNT_W, MAX_PEND, sb_state_e, reg_hit().
package hazard_scoreboard_pkg;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned MAX_PEND = 3;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } sb_state_e;

    // True when a register index selects architectural register r.
    function automatic logic reg_hit(input logic [REG_W-1:0] idx, input int unsigned r);
        return idx == REG_W'(r);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Purpose: bundles the ID decode fields, WB retire, control inputs and the
//          scoreboard's pipeline-control outputs.
// Modports: master = pipeline side (drives decode/retire, observes controls),
//           slave  = scoreboard side.
interface hazard_scoreboard_if;
    import hazard_scoreboard_pkg::*;

    logic                 id_valid;
    logic [REG_W-1:0]     id_src1;
    logic                 id_src1_used;
    logic [REG_W-1:0]     id_src2;
    logic                 id_src2_used;
    logic                 id_wb_en;
    logic [REG_W-1:0]     id_dest;
    logic                 wb_en;
    logic [REG_W-1:0]     wb_dest;
    logic                 branch_taken;
    logic                 mem_busy;

    logic                 stall;
    logic                 freeze;
    logic                 flush;
    logic                 issue;
    logic [NUM_REGS-1:0]  pend_mask;
    logic                 err;

    modport master (
        output id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
               id_wb_en, id_dest, wb_en, wb_dest, branch_taken, mem_busy,
        input  stall, freeze, flush, issue, pend_mask, err
    );

    modport slave (
        input  id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
               id_wb_en, id_dest, wb_en, wb_dest, branch_taken, mem_busy,
        output stall, freeze, flush, issue, pend_mask, err
    );

endinterface

// File: rtl/hazard_scoreboard_sb_counter.sv
// Purpose: per-register in-flight write counter with a sticky underflow flag.
// Ports: clk, rst (async active-high), i_inc (issue writes this reg),
//        i_dec (WB retires this reg), o_cnt (pending writes), o_err (sticky).
module sb_counter
    import hazard_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_err
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Simultaneous issue and retire cancel; a retire at zero is an underflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (i_inc && !i_dec) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (i_dec && !i_inc) begin
            if (r_cnt == '0) begin
                r_err <= 1'b1;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_err = r_err;

endmodule

// File: rtl/hazard_scoreboard.sv
// Purpose: sequences ID->EXE issue. Tracks in-flight register writes, stalls
//          ID on RAW hazards and counter saturation, freezes on mem_busy and
//          holds the branch flush window.
// Ports: clk, rst (async active-high), sb (slave modport: decode fields,
//        retire, branch_taken, mem_busy in; stall/freeze/flush/issue,
//        pend_mask, err out).
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_scoreboard_if.slave    sb
);

    localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);

    sb_state_e        r_state;
    sb_state_e        w_state_nxt;
    logic [FC_W-1:0]  r_flush_cnt;
    logic [FC_W-1:0]  w_flush_cnt_nxt;

    logic [CNT_W-1:0]     w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0]  w_inc;
    logic [NUM_REGS-1:0]  w_dec;
    logic [NUM_REGS-1:0]  w_pend;
    logic [NUM_REGS-1:0]  w_err_vec;
    logic [NUM_REGS-1:0]  w_busy;

    logic w_raw;
    logic w_sat;
    logic w_flush;
    logic w_issue;

    // One counter per architectural register.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        assign w_inc[g]  = w_issue && sb.id_wb_en && reg_hit(sb.id_dest, g);
        assign w_dec[g]  = sb.wb_en && reg_hit(sb.wb_dest, g);
        assign w_busy[g] = (w_cnt[g] != '0);
        // The last outstanding write retiring this cycle is already readable
        // because the register file writes on the falling edge.
        assign w_pend[g] = w_busy[g] && !(w_dec[g] && (w_cnt[g] == CNT_W'(1)));

        sb_counter u_cnt (
            .clk   (clk),
            .rst   (rst),
            .i_inc (w_inc[g]),
            .i_dec (w_dec[g]),
            .o_cnt (w_cnt[g]),
            .o_err (w_err_vec[g])
        );
    end

    // Hazard detection against the two read ports and the destination counter.
    assign w_raw = sb.id_valid &&
                   ((sb.id_src1_used && w_pend[sb.id_src1]) ||
                    (sb.id_src2_used && w_pend[sb.id_src2]));
    assign w_sat = sb.id_valid && sb.id_wb_en &&
                   (w_cnt[sb.id_dest] == CNT_W'(MAX_PEND)) && !w_dec[sb.id_dest];

    assign w_flush = sb.branch_taken || (r_state == ST_FLUSH);
    assign w_issue = sb.id_valid && !sb.mem_busy && !w_flush && !w_raw && !w_sat;

    // Flush-window state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Next-state logic; flush_cnt keeps counting while frozen.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        unique case (r_state)
            ST_RUN: begin
                if (sb.branch_taken && (FLUSH_CYCLES > 1)) begin
                    w_state_nxt     = ST_FLUSH;
                    w_flush_cnt_nxt = FC_RELOAD;
                end
            end
            ST_FLUSH: begin
                if (sb.branch_taken) begin
                    w_flush_cnt_nxt = FC_RELOAD;
                end else if (r_flush_cnt <= FC_W'(1)) begin
                    w_state_nxt     = ST_RUN;
                    w_flush_cnt_nxt = '0;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - FC_W'(1);
                end
            end
            default: begin
                w_state_nxt     = ST_RUN;
                w_flush_cnt_nxt = '0;
            end
        endcase
    end

    // Output muxing: freeze dominates, then flush, then stall.
    assign sb.freeze    = sb.mem_busy;
    assign sb.flush     = w_flush;
    assign sb.stall     = !sb.mem_busy && !w_flush && (w_raw || w_sat);
    assign sb.issue     = w_issue;
    assign sb.pend_mask = w_busy;
    assign sb.err       = |w_err_vec;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    typedef struct packed {
        logic        rst;
        logic        v;
        logic [3:0]  s1;
        logic        s1u;
        logic [3:0]  s2;
        logic        s2u;
        logic        wbe;
        logic [3:0]  d;
        logic        wb;
        logic [3:0]  wbd;
        logic        br;
        logic        mb;
        logic [20:0] exp;   // {stall, freeze, flush, issue, err, pend_mask}
    } stim_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [20:0] q[$];

    hazard_scoreboard_if sb_bus ();

    hazard_scoreboard #(.FLUSH_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] ex(input int stall, input int frz, input int fl,
                                       input int iss, input int err, input int mask);
        return {1'(stall), 1'(frz), 1'(fl), 1'(iss), 1'(err), 16'(mask)};
    endfunction

    function automatic stim_t mk(input int r, input int v, input int s1, input int s1u,
                                 input int s2, input int s2u, input int wbe, input int d,
                                 input int wb, input int wbd, input int br, input int mb,
                                 input logic [20:0] e);
        stim_t s;
        s.rst = 1'(r);   s.v   = 1'(v);
        s.s1  = 4'(s1);  s.s1u = 1'(s1u);
        s.s2  = 4'(s2);  s.s2u = 1'(s2u);
        s.wbe = 1'(wbe); s.d   = 4'(d);
        s.wb  = 1'(wb);  s.wbd = 4'(wbd);
        s.br  = 1'(br);  s.mb  = 1'(mb);
        s.exp = e;
        return s;
    endfunction

    function automatic stim_t idle(input int wb, input int wbd, input logic [20:0] e);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, wb, wbd, 0, 0, e);
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue its expectation.
    task automatic apply(input stim_t s);
        @(negedge clk);
        rst                 = s.rst;
        sb_bus.id_valid     = s.v;
        sb_bus.id_src1      = s.s1;
        sb_bus.id_src1_used = s.s1u;
        sb_bus.id_src2      = s.s2;
        sb_bus.id_src2_used = s.s2u;
        sb_bus.id_wb_en     = s.wbe;
        sb_bus.id_dest      = s.d;
        sb_bus.wb_en        = s.wb;
        sb_bus.wb_dest      = s.wbd;
        sb_bus.branch_taken = s.br;
        sb_bus.mem_busy     = s.mb;
        q.push_back(s.exp);
    endtask

    task automatic test_reset();
        stim_t s[$];
        logic [20:0] got, want;
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0)));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0)));
        s.push_back(idle(0, 0, ex(0, 0, 0, 0, 0, 0)));
        foreach (s[i]) begin
            apply(s[i]);
            #1;
            got = {sb_bus.stall, sb_bus.freeze, sb_bus.flush, sb_bus.issue, sb_bus.err, sb_bus.pend_mask};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL reset[%0d]: scoreboard empty, got=%b_%h", i, got[20:16], got[15:0]);
            end else begin
                want = q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL reset[%0d]: got s/fz/fl/is/er=%b mask=%h want %b mask=%h",
                             i, got[20:16], got[15:0], want[20:16], want[15:0]);
                end
            end
        end
    endtask

    task automatic test_raw();
        stim_t s[$];
        logic [20:0] got, want;
        s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 16'h0000)));
        s.push_back(mk(0, 1, 1, 1, 0, 0, 1, 4, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 16'h0002)));
        s.push_back(mk(0, 1, 1, 1, 0, 0, 1, 4, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 16'h0002)));
        s.push_back(mk(0, 1, 1, 1, 0, 0, 1, 4, 1, 1, 0, 0, ex(0, 0, 0, 1, 0, 16'h0002)));
        s.push_back(idle(1, 4, ex(0, 0, 0, 0, 0, 16'h0010)));
        s.push_back(idle(0, 0, ex(0, 0, 0, 0, 0, 16'h0000)));
        s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 16'h0000)));
        s.push_back(mk(0, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 16'h0400)));
        s.push_back(mk(0, 1, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 16'h0400)));
        s.push_back(idle(1, 10, ex(0, 0, 0, 0, 0, 16'h0400)));
        s.push_back(idle(0, 0, ex(0, 0, 0, 0, 0, 16'h0000)));
        foreach (s[i]) begin
            apply(s[i]);
            #1;
            got = {sb_bus.stall, sb_bus.freeze, sb_bus.flush, sb_bus.issue, sb_bus.err, sb_bus.pend_mask};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL raw[%0d]: scoreboard empty, got=%b_%h", i, got[20:16], got[15:0]);
            end else begin
                want = q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL raw[%0d]: got s/fz/fl/is/er=%b mask=%h want %b mask=%h",
                             i, got[20:16], got[15:0], want[20:16], want[15:0]);
                end
            end
        end
    endtask

    task automatic test_saturate();
        stim_t s[$];
        logic [20:0] got, want;
        s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 16'h0000)));
        s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 16'h0004)));
        s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 16'h0004)));
        s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 16'h0004)));
        s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 2, 1, 2, 0, 0, ex(0, 0, 0, 1, 0, 16'h0004)));
        s.push_back(idle(1, 2, ex(0, 0, 0, 0, 0, 16'h0004)));
        s.push_back(idle(1, 2, ex(0, 0, 0, 0, 0, 16'h0004)));
        s.push_back(idle(1, 2, ex(0, 0, 0, 0, 0, 16'h0004)));
        s.push_back(idle(0, 0, ex(0, 0, 0, 0, 0, 16'h0000)));
        foreach (s[i]) begin
            apply(s[i]);
            #1;
            got = {sb_bus.stall, sb_bus.freeze, sb_bus.flush, sb_bus.issue, sb_bus.err, sb_bus.pend_mask};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL sat[%0d]: scoreboard empty, got=%b_%h", i, got[20:16], got[15:0]);
            end else begin
                want = q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL sat[%0d]: got s/fz/fl/is/er=%b mask=%h want %b mask=%h",
                             i, got[20:16], got[15:0], want[20:16], want[15:0]);
                end
            end
        end
    endtask

    task automatic test_same_cycle();
        stim_t s[$];
        logic [20:0] got, want;
        s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 16'h0000)));
        s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3, 1, 3, 0, 0, ex(0, 0, 0, 1, 0, 16'h0008)));
        s.push_back(idle(0, 0, ex(0, 0, 0, 0, 0, 16'h0008)));
        s.push_back(idle(1, 3, ex(0, 0, 0, 0, 0, 16'h0008)));
        s.push_back(idle(0, 0, ex(0, 0, 0, 0, 0, 16'h0000)));
        foreach (s[i]) begin
            apply(s[i]);
            #1;
            got = {sb_bus.stall, sb_bus.freeze, sb_bus.flush, sb_bus.issue, sb_bus.err, sb_bus.pend_mask};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL same_cycle[%0d]: scoreboard empty, got=%b_%h", i, got[20:16], got[15:0]);
            end else begin
                want = q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL same_cycle[%0d]: got s/fz/fl/is/er=%b mask=%h want %b mask=%h",
                             i, got[20:16], got[15:0], want[20:16], want[15:0]);
                end
            end
        end
    endtask

    task automatic test_flush();
        stim_t s[$];
        logic [20:0] got, want;
        s.push_back(mk(0, 1, 0, 1, 0, 0, 1, 6, 0, 0, 1, 0, ex(0, 0, 1, 0, 0, 16'h0000)));
        s.push_back(mk(0, 1, 0, 1, 0, 0, 1, 6, 0, 0, 0, 0, ex(0, 0, 1, 0, 0, 16'h0000)));
        s.push_back(mk(0, 1, 0, 1, 0, 0, 1, 6, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 16'h0000)));
        s.push_back(idle(1, 6, ex(0, 0, 0, 0, 0, 16'h0040)));
        s.push_back(idle(0, 0, ex(0, 0, 0, 0, 0, 16'h0000)));
        // branch inside the flush window reloads the count
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ex(0, 0, 1, 0, 0, 16'h0000)));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ex(0, 0, 1, 0, 0, 16'h0000)));
        s.push_back(idle(0, 0, ex(0, 0, 1, 0, 0, 16'h0000)));
        s.push_back(idle(0, 0, ex(0, 0, 0, 0, 0, 16'h0000)));
        foreach (s[i]) begin
            apply(s[i]);
            #1;
            got = {sb_bus.stall, sb_bus.freeze, sb_bus.flush, sb_bus.issue, sb_bus.err, sb_bus.pend_mask};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL flush[%0d]: scoreboard empty, got=%b_%h", i, got[20:16], got[15:0]);
            end else begin
                want = q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL flush[%0d]: got s/fz/fl/is/er=%b mask=%h want %b mask=%h",
                             i, got[20:16], got[15:0], want[20:16], want[15:0]);
                end
            end
        end
    endtask

    task automatic test_freeze();
        stim_t s[$];
        logic [20:0] got, want;
        s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 16'h0000)));
        s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 16'h0080)));
        s.push_back(mk(0, 1, 7, 1, 0, 0, 0, 0, 1, 7, 0, 1, ex(0, 1, 0, 0, 0, 16'h0080)));
        s.push_back(mk(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, ex(0, 1, 0, 0, 0, 16'h0080)));
        s.push_back(mk(0, 1, 7, 1, 0, 0, 0, 0, 1, 7, 0, 1, ex(0, 1, 0, 0, 0, 16'h0080)));
        s.push_back(mk(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, ex(0, 1, 0, 0, 0, 16'h0000)));
        s.push_back(mk(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 16'h0000)));
        // branch while frozen: both controls high, window still counts down
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ex(0, 1, 1, 0, 0, 16'h0000)));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(0, 1, 1, 0, 0, 16'h0000)));
        s.push_back(idle(0, 0, ex(0, 0, 0, 0, 0, 16'h0000)));
        foreach (s[i]) begin
            apply(s[i]);
            #1;
            got = {sb_bus.stall, sb_bus.freeze, sb_bus.flush, sb_bus.issue, sb_bus.err, sb_bus.pend_mask};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL freeze[%0d]: scoreboard empty, got=%b_%h", i, got[20:16], got[15:0]);
            end else begin
                want = q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL freeze[%0d]: got s/fz/fl/is/er=%b mask=%h want %b mask=%h",
                             i, got[20:16], got[15:0], want[20:16], want[15:0]);
                end
            end
        end
    endtask

    task automatic test_err_reset();
        stim_t s[$];
        logic [20:0] got, want;
        s.push_back(idle(1, 5, ex(0, 0, 0, 0, 0, 16'h0000)));
        s.push_back(idle(0, 0, ex(0, 0, 0, 0, 1, 16'h0000)));
        s.push_back(idle(0, 0, ex(0, 0, 0, 0, 1, 16'h0000)));
        s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, ex(0, 0, 0, 1, 1, 16'h0000)));
        s.push_back(mk(0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 1, 16'h0200)));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 16'h0000)));
        s.push_back(idle(0, 0, ex(0, 0, 0, 0, 0, 16'h0000)));
        s.push_back(idle(1, 9, ex(0, 0, 0, 0, 0, 16'h0000)));
        s.push_back(idle(0, 0, ex(0, 0, 0, 0, 1, 16'h0000)));
        foreach (s[i]) begin
            apply(s[i]);
            #1;
            got = {sb_bus.stall, sb_bus.freeze, sb_bus.flush, sb_bus.issue, sb_bus.err, sb_bus.pend_mask};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL err_reset[%0d]: scoreboard empty, got=%b_%h", i, got[20:16], got[15:0]);
            end else begin
                want = q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL err_reset[%0d]: got s/fz/fl/is/er=%b mask=%h want %b mask=%h",
                             i, got[20:16], got[15:0], want[20:16], want[15:0]);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst                 = 1'b1;
        sb_bus.id_valid     = 1'b0;
        sb_bus.id_src1      = '0;
        sb_bus.id_src1_used = 1'b0;
        sb_bus.id_src2      = '0;
        sb_bus.id_src2_used = 1'b0;
        sb_bus.id_wb_en     = 1'b0;
        sb_bus.id_dest      = '0;
        sb_bus.wb_en        = 1'b0;
        sb_bus.wb_dest      = '0;
        sb_bus.branch_taken = 1'b0;
        sb_bus.mem_busy     = 1'b0;

        test_reset();
        test_raw();
        test_saturate();
        test_same_cycle();
        test_flush();
        test_freeze();
        test_err_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
